// File: rtl/stage2_writeback.sv
// stage2_writeback: result sink for the stage-2 datapath.
// Packs the tagged operand stream into 2*WIDTH words, buffers them in a
// small FIFO and writes them to the 6-bank result SRAM. Completion is
// flagged once a stage-7 beat has been seen and every word is committed.
//
// Completion FSM:
//   state    | meaning
//   ST_RUN   | normal streaming, no stage-7 beat seen yet
//   ST_DRAIN | stage-7 seen, waiting for half register and FIFO to empty
//   ST_DONE  | everything committed; done_o high, further beats ignored
module stage2_writeback #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic                 CLK_i,
  input  logic                 RST_ni,
  input  logic                 valid_i,
  input  logic [2:0]           stage_i,
  input  logic [WIDTH-1:0]     operand1_i,
  input  logic [WIDTH-1:0]     operand2_i,
  output logic                 stall_o,
  output logic                 wr_en_o,
  input  logic                 wr_ready_i,
  output logic [2:0]           wr_bank_o,
  output logic [ADDR_W-1:0]    wr_addr_o,
  output logic [2*WIDTH-1:0]   wr_data_o,
  output logic                 done_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] S6_BASE = {1'b1, {(ADDR_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state, next_state;

  // FIFO storage and bookkeeping
  logic [2:0]         mem_bank [DEPTH];
  logic [ADDR_W-1:0]  mem_addr [DEPTH];
  logic [2*WIDTH-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  // Half-word register for stages 0..5
  logic               half_valid;
  logic [2:0]         half_stage;
  logic [WIDTH-1:0]   half_data;

  // Per-stage word address counters
  logic [ADDR_W-1:0]  addr_cnt [6];
  logic [ADDR_W-1:0]  addr_s6;

  // Datapath control
  logic               accept;
  logic               is_pair_stage;
  logic               same_stage;
  logic               flush_half;
  logic               word_new;
  logic               take_half;
  logic               pop;
  logic [CNT_W-1:0]   n_push;

  // Entry A: zero-padded pending half. Entry B: the word built this cycle.
  logic [2:0]         a_bank;
  logic [ADDR_W-1:0]  a_addr;
  logic [2*WIDTH-1:0] a_data;
  logic [2:0]         b_bank;
  logic [ADDR_W-1:0]  b_addr;
  logic [2*WIDTH-1:0] b_data;
  logic [2:0]         e0_bank;
  logic [ADDR_W-1:0]  e0_addr;
  logic [2*WIDTH-1:0] e0_data;

  // Stall only depends on the registered occupancy: fewer than two free slots.
  assign stall_o = (CNT_W'(DEPTH) - count) < CNT_W'(2);
  assign wr_en_o = (count != '0);
  assign pop     = wr_en_o && wr_ready_i;

  // Head of FIFO drives the SRAM port; zero while empty so reset outputs are clean.
  always_comb begin
    wr_bank_o = '0;
    wr_addr_o = '0;
    wr_data_o = '0;
    if (wr_en_o) begin
      wr_bank_o = mem_bank[rd_ptr];
      wr_addr_o = mem_addr[rd_ptr];
      wr_data_o = mem_data[rd_ptr];
    end
  end

  // Classify the incoming beat and decide which words are enqueued this cycle.
  always_comb begin
    accept        = valid_i && !stall_o && (state != ST_DONE);
    is_pair_stage = (stage_i <= 3'd5);
    same_stage    = half_valid && (half_stage == stage_i);
    // A pending half is closed out by any beat of a different stage,
    // including stage 6 and the stage-7 flush beat.
    flush_half    = accept && half_valid && !same_stage;
    word_new      = accept && ((stage_i == 3'd6) || (is_pair_stage && same_stage));
    take_half     = accept && is_pair_stage && !same_stage;
    n_push        = CNT_W'(flush_half) + CNT_W'(word_new);
  end

  // Build the two candidate FIFO entries; pending half always goes first.
  always_comb begin
    a_bank = half_stage;
    a_addr = addr_cnt[half_stage];
    a_data = {{WIDTH{1'b0}}, half_data};
    if (stage_i == 3'd6) begin
      b_bank = 3'd5;
      b_addr = addr_s6;
      b_data = {operand2_i, operand1_i};
    end else begin
      b_bank = stage_i;
      b_addr = addr_cnt[stage_i];
      b_data = {operand1_i, half_data};
    end
    if (flush_half) begin
      e0_bank = a_bank;
      e0_addr = a_addr;
      e0_data = a_data;
    end else begin
      e0_bank = b_bank;
      e0_addr = b_addr;
      e0_data = b_data;
    end
  end

  // FIFO storage writes; one or two consecutive slots per cycle.
  always_ff @(posedge CLK_i) begin
    if (flush_half || word_new) begin
      mem_bank[wr_ptr] <= e0_bank;
      mem_addr[wr_ptr] <= e0_addr;
      mem_data[wr_ptr] <= e0_data;
    end
    if (flush_half && word_new) begin
      mem_bank[wr_ptr + PTR_W'(1)] <= b_bank;
      mem_addr[wr_ptr + PTR_W'(1)] <= b_addr;
      mem_data[wr_ptr + PTR_W'(1)] <= b_data;
    end
  end

  // FIFO pointers and occupancy; reset drops anything buffered.
  always_ff @(posedge CLK_i) begin
    if (!RST_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + n_push - CNT_W'(pop);
    end
  end

  // Half-word register: holds the first operand of a pair and its stage.
  always_ff @(posedge CLK_i) begin
    if (!RST_ni) begin
      half_valid <= 1'b0;
      half_stage <= 3'd0;
      half_data  <= '0;
    end else if (accept) begin
      half_valid <= take_half;
      if (take_half) begin
        half_stage <= stage_i;
        half_data  <= operand1_i;
      end
    end
  end

  // Address counters advance on enqueue; stage 6 stays in the upper half of bank 5.
  always_ff @(posedge CLK_i) begin
    if (!RST_ni) begin
      for (int i = 0; i < 6; i++) begin
        addr_cnt[i] <= '0;
      end
      addr_s6 <= S6_BASE;
    end else begin
      if (flush_half) begin
        addr_cnt[half_stage] <= addr_cnt[half_stage] + ADDR_W'(1);
      end
      if (word_new && is_pair_stage) begin
        addr_cnt[stage_i] <= addr_cnt[stage_i] + ADDR_W'(1);
      end
      if (word_new && (stage_i == 3'd6)) begin
        addr_s6 <= {1'b1, addr_s6[ADDR_W-2:0] + (ADDR_W-1)'(1)};
      end
    end
  end

  // Completion FSM state register.
  always_ff @(posedge CLK_i) begin
    if (!RST_ni) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  // Completion FSM next-state: arm on stage 7, finish once fully drained.
  always_comb begin
    next_state = state;
    case (state)
      ST_RUN: begin
        if (accept && (stage_i == 3'd7)) begin
          next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((count == '0) && !half_valid) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: next_state = ST_DONE;
      default: next_state = ST_RUN;
    endcase
  end

  // Completion FSM outputs.
  always_comb begin
    done_o = (state == ST_DONE);
  end

endmodule

// File: tb/tb_stage2_writeback.sv
// Testbench for stage2_writeback: directed stimulus, a queue-based model of
// the expected SRAM writes, a per-cycle compare process, and literal checks.
module tb_stage2_writeback;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [2:0]  bank;
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [2:0]  stage = 3'd0;
  logic [15:0] op1 = '0;
  logic [15:0] op2 = '0;
  logic        wr_ready = 1'b1;
  logic        stall_o, wr_en_o, done_o;
  logic [2:0]  wr_bank_o;
  logic [11:0] wr_addr_o;
  logic [31:0] wr_data_o;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Model state
  wr_t         mq[$];
  wr_t         wlog[$];
  logic [11:0] mcnt [6];
  logic [11:0] mcnt6;
  bit          mhalf_v, mflush, mdone;
  int          mhalf_s;
  logic [15:0] mhalf_d;
  bit          seen_en;
  wr_t         seen;

  stage2_writeback #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .CLK_i(clk), .RST_ni(rst_n), .valid_i(valid), .stage_i(stage),
    .operand1_i(op1), .operand2_i(op2), .stall_o(stall_o), .wr_en_o(wr_en_o),
    .wr_ready_i(wr_ready), .wr_bank_o(wr_bank_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_w(input string nm, input int idx, input logic [2:0] b,
                       input logic [11:0] a, input logic [31:0] d);
    if (wlog.size() <= idx) begin
      chk({nm, "_present"}, 32'(wlog.size()), 32'(idx + 1));
    end else begin
      chk({nm, "_bank"}, 32'(wlog[idx].bank), 32'(b));
      chk({nm, "_addr"}, 32'(wlog[idx].addr), 32'(a));
      chk({nm, "_data"}, wlog[idx].data, d);
    end
  endtask

  function automatic void push_half();
    mq.push_back('{bank: 3'(mhalf_s), addr: mcnt[mhalf_s], data: {16'h0000, mhalf_d}});
    mcnt[mhalf_s] = mcnt[mhalf_s] + 12'd1;
    mhalf_v = 1'b0;
  endfunction

  // Behavioural model: advances on every rising edge from the spec rules.
  initial begin
    bit pop, acc, dn;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        for (int i = 0; i < 6; i++) mcnt[i] = 12'h000;
        mcnt6 = 12'h800;
        mhalf_v = 1'b0; mhalf_s = 0; mhalf_d = '0;
        mflush = 1'b0; mdone = 1'b0;
      end else begin
        if (cmp_en && seen_en && wr_ready) wlog.push_back(seen);
        pop = (mq.size() > 0) && wr_ready;
        acc = valid && !(mq.size() >= DEPTH - 1) && !mdone;
        dn  = mdone || (mflush && mq.size() == 0 && !mhalf_v);
        if (pop) void'(mq.pop_front());
        if (acc) begin
          if (stage == 3'd7) begin
            if (mhalf_v) push_half();
            mflush = 1'b1;
          end else if (stage == 3'd6) begin
            if (mhalf_v) push_half();
            mq.push_back('{bank: 3'd5, addr: mcnt6, data: {op2, op1}});
            mcnt6 = (mcnt6 == 12'hFFF) ? 12'h800 : mcnt6 + 12'd1;
          end else if (mhalf_v && mhalf_s == int'(stage)) begin
            mq.push_back('{bank: stage, addr: mcnt[stage], data: {op1, mhalf_d}});
            mcnt[stage] = mcnt[stage] + 12'd1;
            mhalf_v = 1'b0;
          end else begin
            if (mhalf_v) push_half();
            mhalf_v = 1'b1; mhalf_s = int'(stage); mhalf_d = op1;
          end
        end
        mdone = dn;
      end
    end
  end

  // Compare process: DUT outputs against the model every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("wr_en", 32'(wr_en_o), 32'(mq.size() != 0));
        chk("stall", 32'(stall_o), 32'(mq.size() >= DEPTH - 1));
        chk("done", 32'(done_o), 32'(mdone));
        if (mq.size() != 0) begin
          chk("head_bank", 32'(wr_bank_o), 32'(mq[0].bank));
          chk("head_addr", 32'(wr_addr_o), 32'(mq[0].addr));
          chk("head_data", wr_data_o, mq[0].data);
        end
        seen_en = wr_en_o;
        seen = '{bank: wr_bank_o, addr: wr_addr_o, data: wr_data_o};
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
    bit acc_now;
    bit ok;
    ok = 1'b0;
    valid = 1'b1; stage = s; op1 = a; op2 = b;
    for (int k = 0; k < 100 && !ok; k++) begin
      acc_now = !stall_o;
      @(negedge clk);
      if (acc_now) ok = 1'b1;
    end
    valid = 1'b0;
    if (!ok) chk("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit got_done;
    // Reset state
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_wr_en", 32'(wr_en_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_bank", 32'(wr_bank_o), 32'd0);
    chk("rst_addr", 32'(wr_addr_o), 32'd0);
    chk("rst_data", wr_data_o, 32'd0);
    rst_n = 1'b1;

    // Stage 0 pairs
    wlog.delete();
    send(3'd0, 16'h1111, 16'h0);
    send(3'd0, 16'h2222, 16'h0);
    send(3'd0, 16'h3333, 16'h0);
    send(3'd0, 16'h4444, 16'h0);
    idle(5);
    chk("s0_count", 32'(wlog.size()), 32'd2);
    chk_w("s0_w0", 0, 3'd0, 12'h000, 32'h22221111);
    chk_w("s0_w1", 1, 3'd0, 12'h001, 32'h44443333);

    // Stage 6 full words
    wlog.delete();
    send(3'd6, 16'h0005, 16'h3C00);
    send(3'd6, 16'h0009, 16'h3800);
    idle(5);
    chk_w("s6_w0", 0, 3'd5, 12'h800, 32'h3C000005);
    chk_w("s6_w1", 1, 3'd5, 12'h801, 32'h38000009);

    // Backpressure: stall after three buffered words, then drain in order
    do_reset();
    wlog.delete();
    wr_ready = 1'b0;
    send(3'd6, 16'h0010, 16'h0100);
    send(3'd6, 16'h0011, 16'h0101);
    chk("bp_stall_2w", 32'(stall_o), 32'd0);
    send(3'd6, 16'h0012, 16'h0102);
    chk("bp_stall_3w", 32'(stall_o), 32'd1);
    wr_ready = 1'b1;
    for (int k = 3; k < 6; k++) send(3'd6, 16'(16'h0010 + k), 16'(16'h0100 + k));
    idle(6);
    chk("bp_count", 32'(wlog.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      chk_w("bp_w", k, 3'd5, 12'(12'h800 + k), {16'(16'h0100 + k), 16'(16'h0010 + k)});

    // Reset mid-burst with two words buffered and a half pending
    do_reset();
    wr_ready = 1'b0;
    for (int k = 0; k < 5; k++) send(3'd0, 16'(16'h00A1 + k), 16'h0);
    chk("mid_stall", 32'(stall_o), 32'd0);
    chk("mid_wr_en", 32'(wr_en_o), 32'd1);
    do_reset();
    chk("post_rst_wr_en", 32'(wr_en_o), 32'd0);
    chk("post_rst_stall", 32'(stall_o), 32'd0);
    wr_ready = 1'b1;
    wlog.delete();
    send(3'd0, 16'h0101, 16'h0);
    send(3'd0, 16'h0202, 16'h0);
    send(3'd3, 16'h1234, 16'h0);
    send(3'd6, 16'h5678, 16'h9ABC);
    idle(5);
    chk_w("rst_pair", 0, 3'd0, 12'h000, 32'h02020101);
    chk_w("dual_half", 1, 3'd3, 12'h000, 32'h00001234);
    chk_w("dual_full", 2, 3'd5, 12'h800, 32'h9ABC5678);

    // Flush and completion
    do_reset();
    wlog.delete();
    send(3'd4, 16'hAAAA, 16'h0);
    send(3'd5, 16'hBBBB, 16'h0);
    send(3'd7, 16'h0000, 16'h0);
    chk("fl_done_0", 32'(done_o), 32'd0);
    @(negedge clk);
    chk("fl_done_1", 32'(done_o), 32'd0);
    chk("fl_empty", 32'(wr_en_o), 32'd0);
    got_done = 1'b0;
    for (int k = 0; k < 20 && !got_done; k++) begin
      @(negedge clk);
      if (done_o) got_done = 1'b1;
    end
    chk("fl_done_wait", 32'(got_done), 32'd1);
    chk_w("fl_w0", 0, 3'd4, 12'h000, 32'h0000AAAA);
    chk_w("fl_w1", 1, 3'd5, 12'h000, 32'h0000BBBB);
    send(3'd0, 16'h5555, 16'h0);
    send(3'd0, 16'h6666, 16'h0);
    idle(3);
    chk("after_done_wr_en", 32'(wr_en_o), 32'd0);
    chk("after_done_count", 32'(wlog.size()), 32'd2);
    chk("after_done_sticky", 32'(done_o), 32'd1);

    // Stage 1 address wrap at 0xFFF
    do_reset();
    wlog.delete();
    for (int i = 0; i < 4097; i++) begin
      send(3'd1, 16'(i), 16'h0);
      send(3'd1, ~16'(i), 16'h0);
    end
    idle(4);
    chk("wrap_count", 32'(wlog.size()), 32'd4097);
    chk_w("wrap_fff", 4095, 3'd1, 12'hFFF, 32'hF0000FFF);
    chk_w("wrap_000", 4096, 3'd1, 12'h000, 32'hEFFF1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
